leaf_port_bridge: RTL and testbench

- Parametrised buffered bridge between a leaf_interface and an HLS operator kernel inside a page top.
- Supports NUM_IN_PORTS input and NUM_OUT_PORTS output streams, each decoupled by a small per-channel FIFO.
- A frame-level start/drain/done FSM replaces the bare ap_start tie-through used by single-port tops.
- Streams use the vld/ack protocol: a word transfers in any cycle where vld=1 and ack=1; the producer holds data and vld stable until the transfer.

---
 rtl/leaf_port_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_leaf_port_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_port_bridge.sv
// Buffered multi-port bridge between a leaf_interface and an HLS kernel.
// Optional LEAF_PORT_BRIDGE_STALL_CNT_EN adds per-output stall counters.
module leaf_port_bridge_fifo #(
    parameter int W  = 32,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] wr_data,
    input  logic         wr_vld,
    output logic         wr_ack,
    output logic [W-1:0] rd_data,
    output logic         rd_vld,
    input  logic         rd_pop
);
    localparam int DEPTH = 1 << AW;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [W-1:0] mem [DEPTH];
    ptr_t         wr_ptr;
    ptr_t         rd_ptr;
    cnt_t         count;
    cnt_t         count_nx;
    logic         full_q;
    logic         nempty_q;
    logic         init_q;
    logic         push;
    logic         pop;

    // Ack stays low until the first edge after reset is released.
    assign wr_ack  = init_q & ~full_q;
    assign rd_vld  = nempty_q;
    assign rd_data = mem[rd_ptr];
    assign push    = wr_vld & wr_ack;
    assign pop     = rd_pop & nempty_q;

    always_comb begin
        count_nx = count;
        if (push && !pop)
            count_nx = count + cnt_t'(1);
        else if (!push && pop)
            count_nx = count - cnt_t'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            nempty_q <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            init_q   <= 1'b1;
            count    <= count_nx;
            full_q   <= (count_nx == cnt_t'(DEPTH));
            nempty_q <= (count_nx != '0);
            if (push)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end
endmodule

module leaf_port_bridge #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int NUM_IN_PORTS    = 2,
    parameter int NUM_OUT_PORTS   = 2,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int WORDS_PER_FRAME = 64
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ap_start,
    output logic                                  ap_done,
    output logic                                  ap_idle,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  iface_dout,
    input  logic [NUM_IN_PORTS-1:0]               iface_dout_vld,
    output logic [NUM_IN_PORTS-1:0]               iface_dout_ack,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  kern_din,
    output logic [NUM_IN_PORTS-1:0]               kern_din_vld,
    input  logic [NUM_IN_PORTS-1:0]               kern_din_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] kern_dout,
    input  logic [NUM_OUT_PORTS-1:0]              kern_dout_vld,
    output logic [NUM_OUT_PORTS-1:0]              kern_dout_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] iface_din,
    output logic [NUM_OUT_PORTS-1:0]              iface_din_vld,
    input  logic [NUM_OUT_PORTS-1:0]              iface_din_ack,
    output logic                                  kern_start
`ifdef LEAF_PORT_BRIDGE_STALL_CNT_EN
    ,
    output logic [NUM_OUT_PORTS*16-1:0]           stall_cnt
`endif
);
    localparam int W = PAYLOAD_BITS;
    localparam logic [15:0] LAST = 16'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state;
    logic [15:0]              frame_cnt;
    logic                     run;
    logic [NUM_IN_PORTS-1:0]  in_nempty;
    logic                     ch0_xfer;
    logic                     launch;

    assign run          = (state == S_RUN);
    assign kern_din_vld = in_nempty & {NUM_IN_PORTS{run}};
    assign ch0_xfer     = kern_din_vld[0] & kern_din_ack[0];
    assign launch       = (state == S_IDLE) & ap_start;

    for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
        leaf_port_bridge_fifo #(
            .W  (W),
            .AW (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_data (iface_dout[gi*W +: W]),
            .wr_vld  (iface_dout_vld[gi]),
            .wr_ack  (iface_dout_ack[gi]),
            .rd_data (kern_din[gi*W +: W]),
            .rd_vld  (in_nempty[gi]),
            .rd_pop  (kern_din_vld[gi] & kern_din_ack[gi])
        );
    end

    for (genvar gj = 0; gj < NUM_OUT_PORTS; gj++) begin : g_out
        leaf_port_bridge_fifo #(
            .W  (W),
            .AW (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_data (kern_dout[gj*W +: W]),
            .wr_vld  (kern_dout_vld[gj]),
            .wr_ack  (kern_dout_ack[gj]),
            .rd_data (iface_din[gj*W +: W]),
            .rd_vld  (iface_din_vld[gj]),
            .rd_pop  (iface_din_vld[gj] & iface_din_ack[gj])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            frame_cnt  <= '0;
            ap_idle    <= 1'b1;
            ap_done    <= 1'b0;
            kern_start <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    ap_done <= 1'b0;
                    if (ap_start) begin
                        state      <= S_RUN;
                        frame_cnt  <= '0;
                        ap_idle    <= 1'b0;
                        kern_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (ch0_xfer) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (frame_cnt == LAST) begin
                            state      <= S_DRAIN;
                            kern_start <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Done only once nothing is buffered or still in flight.
                    if (!(|iface_din_vld) && !(|kern_dout_vld)) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state      <= S_IDLE;
                    ap_idle    <= 1'b1;
                    ap_done    <= 1'b0;
                    kern_start <= 1'b0;
                end
            endcase
        end
    end

`ifdef LEAF_PORT_BRIDGE_STALL_CNT_EN
    for (genvar gs = 0; gs < NUM_OUT_PORTS; gs++) begin : g_stall
        logic [15:0] cnt_q;
        assign stall_cnt[gs*16 +: 16] = cnt_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                cnt_q <= '0;
            else if (launch)
                cnt_q <= '0;
            else if (kern_dout_vld[gs] && !kern_dout_ack[gs]
                     && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif
endmodule

// File: tb/tb_leaf_port_bridge.sv
// Directed bench for leaf_port_bridge (2 in / 2 out, depth 4, 4 words/frame).
// Define LEAF_PORT_BRIDGE_STALL_CNT_EN to also cover the stall counters.
`timescale 1ns/1ps
module tb_leaf_port_bridge;
    localparam int W  = 32;
    localparam int NI = 2;
    localparam int NO = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ap_start;
    logic            ap_done;
    logic            ap_idle;
    logic [NI*W-1:0] iface_dout;
    logic [NI-1:0]   iface_dout_vld;
    logic [NI-1:0]   iface_dout_ack;
    logic [NI*W-1:0] kern_din;
    logic [NI-1:0]   kern_din_vld;
    logic [NI-1:0]   kern_din_ack;
    logic [NO*W-1:0] kern_dout;
    logic [NO-1:0]   kern_dout_vld;
    logic [NO-1:0]   kern_dout_ack;
    logic [NO*W-1:0] iface_din;
    logic [NO-1:0]   iface_din_vld;
    logic [NO-1:0]   iface_din_ack;
    logic            kern_start;
`ifdef LEAF_PORT_BRIDGE_STALL_CNT_EN
    logic [NO*16-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        kvld;
        logic [31:0] kdata;
        logic        dack;
        logic        exp_kack;
        logic        exp_ivld;
        logic [31:0] exp_idata;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    leaf_port_bridge #(
        .PAYLOAD_BITS    (W),
        .NUM_IN_PORTS    (NI),
        .NUM_OUT_PORTS   (NO),
        .FIFO_DEPTH_BITS (2),
        .WORDS_PER_FRAME (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .iface_dout     (iface_dout),
        .iface_dout_vld (iface_dout_vld),
        .iface_dout_ack (iface_dout_ack),
        .kern_din       (kern_din),
        .kern_din_vld   (kern_din_vld),
        .kern_din_ack   (kern_din_ack),
        .kern_dout      (kern_dout),
        .kern_dout_vld  (kern_dout_vld),
        .kern_dout_ack  (kern_dout_ack),
        .iface_din      (iface_din),
        .iface_din_vld  (iface_din_vld),
        .iface_din_ack  (iface_din_ack),
        .kern_start     (kern_start)
`ifdef LEAF_PORT_BRIDGE_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 32'hB0};
        tbl[2]  = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 32'hB0};
        tbl[3]  = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b1, 32'hB0};
        tbl[4]  = '{1'b1, 32'hB4, 1'b0, 1'b0, 1'b1, 32'hB0};
        tbl[5]  = '{1'b1, 32'hB4, 1'b1, 1'b0, 1'b1, 32'hB0};
        tbl[6]  = '{1'b1, 32'hB4, 1'b1, 1'b1, 1'b1, 32'hB1};
        tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB2};
        tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB3};
        tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB4};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};

        reset_n        = 1'b0;
        ap_start       = 1'b0;
        iface_dout     = '0;
        iface_dout_vld = 2'b11;
        kern_din_ack   = '0;
        kern_dout      = '0;
        kern_dout_vld  = '0;
        iface_din_ack  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_iface_dout_ack", iface_dout_ack, 2'b00);
        chk("rst_kern_dout_ack", kern_dout_ack, 2'b00);
        chk("rst_kern_din_vld", kern_din_vld, 2'b00);
        chk("rst_iface_din_vld", iface_din_vld, 2'b00);
        chk("rst_ap_idle", ap_idle, 1'b1);
        chk("rst_ap_done", ap_done, 1'b0);
        chk("rst_kern_start", kern_start, 1'b0);
        reset_n        = 1'b1;
        iface_dout_vld = 2'b00;
        @(negedge clk);
        chk("post_rst_iface_dout_ack", iface_dout_ack, 2'b11);
        chk("post_rst_kern_dout_ack", kern_dout_ack, 2'b11);

        // Prefetch A0..A3 in IDLE; the fifth attempt sees ack low
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("prefetch_ack0", iface_dout_ack[0], (k < 4));
            chk("idle_gated_vld", kern_din_vld, 2'b00);
            if (k < 4) begin
                iface_dout_vld = 2'b01;
                iface_dout[31:0] = 32'hA0 + k;
            end else begin
                iface_dout_vld = 2'b00;
            end
        end
        chk("prefetch_idle", ap_idle, 1'b1);

        @(negedge clk);
        ap_start     = 1'b1;
        kern_din_ack = 2'b01;
        @(negedge clk);
        ap_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("run_kern_start", kern_start, 1'b1);
            chk("run_vld0", kern_din_vld[0], 1'b1);
            chk("run_data0", kern_din[31:0], 32'hA0 + k);
            @(negedge clk);
        end
        chk("drain_kern_start", kern_start, 1'b0);
        chk("drain_vld_gated", kern_din_vld, 2'b00);
        @(negedge clk);
        chk("frame1_done", ap_done, 1'b1);
        @(negedge clk);
        chk("frame1_done_low", ap_done, 1'b0);
        chk("frame1_idle", ap_idle, 1'b1);
        kern_din_ack = 2'b00;

        // Output backpressure on channel 1, table driven
        iface_din_ack = 2'b01;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("bp_kern_dout_ack1", kern_dout_ack[1], tbl[i].exp_kack);
            chk("bp_iface_din_vld1", iface_din_vld[1], tbl[i].exp_ivld);
            if (tbl[i].exp_ivld)
                chk("bp_iface_din1", iface_din[63:32], tbl[i].exp_idata);
            kern_dout_vld[1]  = tbl[i].kvld;
            kern_dout[63:32]  = tbl[i].kdata;
            iface_din_ack[1]  = tbl[i].dack;
        end

        // Drain with three words stuck in output FIFO 0
        iface_din_ack = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            iface_dout_vld   = 2'b01;
            iface_dout[31:0] = 32'hC0 + k;
            kern_dout_vld    = (k < 3) ? 2'b01 : 2'b00;
            kern_dout[31:0]  = 32'hD0 + k;
        end
        @(negedge clk);
        iface_dout_vld = 2'b00;
        kern_dout_vld  = 2'b00;
        chk("out0_not_full", kern_dout_ack[0], 1'b1);
        chk("out0_head", iface_din[31:0], 32'hD0);
        ap_start     = 1'b1;
        kern_din_ack = 2'b01;
        @(negedge clk);
        ap_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("f2_data0", kern_din[31:0], 32'hC0 + k);
            @(negedge clk);
        end
        repeat (3) begin
            chk("drain_hold_start", kern_start, 1'b0);
            chk("drain_hold_done", ap_done, 1'b0);
            chk("drain_hold_idle", ap_idle, 1'b0);
            @(negedge clk);
        end
        iface_din_ack = 2'b11;
        for (int k = 0; k < 3; k++) begin
            chk("drain_vld0", iface_din_vld[0], 1'b1);
            chk("drain_data0", iface_din[31:0], 32'hD0 + k);
            @(negedge clk);
        end
        chk("drain_empty", iface_din_vld[0], 1'b0);
        chk("drain_done_early", ap_done, 1'b0);
        @(negedge clk);
        chk("drain_done_pulse", ap_done, 1'b1);
        chk("drain_not_idle", ap_idle, 1'b0);
        @(negedge clk);
        chk("drain_done_once", ap_done, 1'b0);
        chk("drain_idle_after", ap_idle, 1'b1);

        // Asynchronous reset mid-RUN with half-full FIFOs
        iface_din_ack = 2'b00;
        kern_din_ack  = 2'b00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            iface_dout_vld    = 2'b11;
            iface_dout        = {32'hF0 + k, 32'hE0 + k};
            kern_dout_vld     = 2'b10;
            kern_dout[63:32]  = 32'h90 + k;
        end
        @(negedge clk);
        iface_dout_vld = 2'b00;
        kern_dout_vld  = 2'b00;
        ap_start       = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        chk("pre_rst_kern_din_vld", kern_din_vld, 2'b11);
        chk("pre_rst_iface_din_vld", iface_din_vld, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_kern_din_vld", kern_din_vld, 2'b00);
        chk("arst_iface_din_vld", iface_din_vld, 2'b00);
        chk("arst_ap_idle", ap_idle, 1'b1);
        chk("arst_kern_start", kern_start, 1'b0);
        chk("arst_iface_dout_ack", iface_dout_ack, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_kern_din_vld", kern_din_vld, 2'b00);
        chk("rel_iface_din_vld", iface_din_vld, 2'b00);
        chk("rel_ap_idle", ap_idle, 1'b1);
        ap_start     = 1'b1;
        kern_din_ack = 2'b11;
        @(negedge clk);
        ap_start = 1'b0;
        chk("rel_run_start", kern_start, 1'b1);
        chk("rel_no_stale_in", kern_din_vld, 2'b00);
        chk("rel_no_stale_out", iface_din_vld, 2'b00);

`ifdef LEAF_PORT_BRIDGE_STALL_CNT_EN
        // Fill output FIFO 0, then hold vld against a full FIFO
        kern_dout_vld   = 2'b01;
        kern_dout[31:0] = 32'h55;
        repeat (14) @(negedge clk);
        kern_dout_vld = 2'b00;
        chk("stall_full_ack", kern_dout_ack[0], 1'b0);
        chk("stall_cnt0", stall_cnt[15:0], 16'd10);
        chk("stall_cnt1", stall_cnt[31:16], 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
